// File: rtl/act_skew_feeder.sv
// act_skew_feeder: left-edge activation feeder for the systolic PE array.
// Accepts one ROWS-wide column vector per cycle and delays row r by r cycles
// so every activation enters the array on its wavefront. Rows with no data
// receive zero bubbles. After the last vector of a tile the skew is flushed
// and o_done pulses in the cycle the final row-(ROWS-1) element appears.
//
// Optional build macro: ACT_FEED_NAN_SQUASH_EN
//   defined   -> accepted bf16 NaN elements are replaced by zero on entry
//   undefined -> elements pass bit-exact
module act_skew_feeder #(
    parameter int ROWS   = 4,
    parameter int MUL_BW = 16,
    parameter int CNT_BW = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_vld,
    input  logic [ROWS*MUL_BW-1:0]   i_data,
    input  logic                     i_last,
    input  logic                     i_abort,
    output logic                     o_rdy,
    output logic [ROWS*MUL_BW-1:0]   o_act,
    output logic [ROWS-1:0]          o_act_vld,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [CNT_BW-1:0]        o_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // The flush counter only ever holds ROWS-1 down to 1.
    localparam int                  FLUSH_BW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [FLUSH_BW-1:0] FLUSH_INIT = FLUSH_BW'(ROWS - 1);
    localparam logic [FLUSH_BW-1:0] FLUSH_LAST = FLUSH_BW'(1);
    localparam logic [CNT_BW-1:0]   COUNT_MAX  = {CNT_BW{1'b1}};

    logic [1:0]             state;
    logic [FLUSH_BW-1:0]    flush_cnt;
    logic [CNT_BW-1:0]      count;
    logic                   accept;
    logic [ROWS*MUL_BW-1:0] head_data;

    // Ready only while a tile can still take vectors; an abort drops the
    // vector presented in the same cycle.
    assign o_rdy   = (state == ST_IDLE) || (state == ST_STREAM);
    assign accept  = i_vld && o_rdy && !i_abort;
    assign o_busy  = (state == ST_STREAM) || (state == ST_FLUSH);
    assign o_done  = (state == ST_DONE);
    assign o_count = count;

`ifdef ACT_FEED_NAN_SQUASH_EN
    // bf16 NaN: all-ones exponent with a non-zero mantissa; infinities survive.
    function automatic logic [MUL_BW-1:0] squash_nan(input logic [MUL_BW-1:0] elem);
        logic is_nan;
        is_nan = (&elem[14:7]) && (|elem[6:0]);
        return is_nan ? '0 : elem;
    endfunction

    // Build the chain heads: squashed data on accept, a zero bubble otherwise.
    always_comb begin
        head_data = '0;
        if (accept) begin
            for (int r = 0; r < ROWS; r++) begin
                head_data[r*MUL_BW +: MUL_BW] = squash_nan(i_data[r*MUL_BW +: MUL_BW]);
            end
        end
    end
`else
    assign head_data = accept ? i_data : '0;
`endif

    // Tile sequencing, flush countdown and the saturating accepted-vector count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
            count     <= '0;
        end else if (i_abort) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
            count     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_STREAM: begin
                    if (accept) begin
                        if (count != COUNT_MAX) begin
                            count <= count + 1'b1;
                        end
                        if (!i_last) begin
                            state <= ST_STREAM;
                        end else if (ROWS == 1) begin
                            state <= ST_DONE;
                        end else begin
                            state     <= ST_FLUSH;
                            flush_cnt <= FLUSH_INIT;
                        end
                    end
                end
                ST_FLUSH: begin
                    flush_cnt <= flush_cnt - 1'b1;
                    if (flush_cnt == FLUSH_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    count <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Row r owns r+1 free-running stages; the last stage drives the array.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [MUL_BW-1:0] data_q [0:r];
        logic              vld_q  [0:r];

        // Shift this row's chain every clock, loading the head from the accept path.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k <= r; k++) begin
                    data_q[k] <= '0;
                    vld_q[k]  <= 1'b0;
                end
            end else if (i_abort) begin
                for (int k = 0; k <= r; k++) begin
                    data_q[k] <= '0;
                    vld_q[k]  <= 1'b0;
                end
            end else begin
                data_q[0] <= head_data[r*MUL_BW +: MUL_BW];
                vld_q[0]  <= accept;
                for (int k = 1; k <= r; k++) begin
                    data_q[k] <= data_q[k-1];
                    vld_q[k]  <= vld_q[k-1];
                end
            end
        end

        assign o_act[r*MUL_BW +: MUL_BW] = data_q[r];
        assign o_act_vld[r]              = vld_q[r];
    end

endmodule

// File: tb/tb_act_skew_feeder.sv
// tb_act_skew_feeder: scoreboard bench for act_skew_feeder.
// The driver keeps a tile-level reference model and pushes, per row, each
// accepted element with the cycle it must appear on; a negedge monitor pops
// and compares every cycle. Build with ACT_FEED_NAN_SQUASH_EN to exercise
// the NaN squash variant.
module tb_act_skew_feeder;

    localparam int ROWS   = 4;
    localparam int MUL_BW = 16;
    localparam int CNT_BW = 16;

    typedef struct packed {
        logic [MUL_BW-1:0] data;
        logic [31:0]       stamp;
    } elem_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   i_vld;
    logic [ROWS*MUL_BW-1:0] i_data;
    logic                   i_last;
    logic                   i_abort;
    logic                   o_rdy;
    logic [ROWS*MUL_BW-1:0] o_act;
    logic [ROWS-1:0]        o_act_vld;
    logic                   o_busy;
    logic                   o_done;
    logic [CNT_BW-1:0]      o_count;

    int                vectors     = 0;
    int                miscompares = 0;
    int                cyc         = 0;
    bit                mon_en      = 1'b0;
    bit                flushing;
    bit                streaming;
    int                last_edge;
    logic [CNT_BW-1:0] model_count;
    elem_t             rowq [ROWS][$];

    act_skew_feeder #(
        .ROWS   (ROWS),
        .MUL_BW (MUL_BW),
        .CNT_BW (CNT_BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_vld     (i_vld),
        .i_data    (i_data),
        .i_last    (i_last),
        .i_abort   (i_abort),
        .o_rdy     (o_rdy),
        .o_act     (o_act),
        .o_act_vld (o_act_vld),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_count   (o_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Element as it should enter the array after the optional NaN rule.
    function automatic logic [MUL_BW-1:0] model_elem(input logic [MUL_BW-1:0] x);
`ifdef ACT_FEED_NAN_SQUASH_EN
        if (x[14:7] == 8'hFF && x[6:0] != 7'd0) return '0;
`endif
        return x;
    endfunction

    task automatic clear_model();
        flushing    = 1'b0;
        streaming   = 1'b0;
        last_edge   = -1000;
        model_count = '0;
        for (int r = 0; r < ROWS; r++) rowq[r].delete();
    endtask

    // Tile-level model update for one clock edge.
    task automatic model_edge(input bit acc, input logic [ROWS*MUL_BW-1:0] data,
                              input logic last, input logic abort);
        elem_t e;
        if (abort) begin
            clear_model();
        end else if (flushing && cyc == last_edge + ROWS) begin
            clear_model();
        end else if (acc) begin
            if (model_count != {CNT_BW{1'b1}}) model_count = model_count + 1'b1;
            streaming = 1'b1;
            for (int r = 0; r < ROWS; r++) begin
                e.data  = model_elem(data[r*MUL_BW +: MUL_BW]);
                e.stamp = 32'(cyc + r);
                rowq[r].push_back(e);
            end
            if (last) begin
                flushing  = 1'b1;
                streaming = 1'b0;
                last_edge = cyc;
            end
        end
    endtask

    // Present one cycle of inputs, clock it, and advance the model.
    task automatic apply_stimulus(input logic vld, input logic [ROWS*MUL_BW-1:0] data,
                                  input logic last, input logic abort);
        bit acc;
        i_vld   = vld;
        i_data  = data;
        i_last  = last;
        i_abort = abort;
        acc     = vld && !flushing && !abort;
        @(posedge clk);
        cyc++;
        if (rst) model_edge(acc, data, last, abort);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, {ROWS{16'hDEAD}}, 1'b0, 1'b0);
    endtask

    task automatic check_output();
        bit    exp_vld;
        elem_t e;
        check_eq("o_rdy",   32'(o_rdy),   32'(!flushing));
        check_eq("o_busy",  32'(o_busy),  32'(streaming || (flushing && cyc < last_edge + ROWS - 1)));
        check_eq("o_done",  32'(o_done),  32'(flushing && cyc == last_edge + ROWS - 1));
        check_eq("o_count", 32'(o_count), 32'(model_count));
        for (int r = 0; r < ROWS; r++) begin
            exp_vld = (rowq[r].size() > 0) && (rowq[r][0].stamp == 32'(cyc));
            check_eq($sformatf("row%0d_vld", r), 32'(o_act_vld[r]), 32'(exp_vld));
            if (exp_vld) begin
                e = rowq[r].pop_front();
                check_eq($sformatf("row%0d_data", r), 32'(o_act[r*MUL_BW +: MUL_BW]), 32'(e.data));
            end else begin
                check_eq($sformatf("row%0d_bubble", r), 32'(o_act[r*MUL_BW +: MUL_BW]), 32'(0));
            end
        end
    endtask

    // Monitor: compare every cycle away from the active edge.
    always @(negedge clk) begin
        if (mon_en && rst) check_output();
    end

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_act"},   32'(o_act != '0), 32'(0));
        check_eq({tag, "_vld"},   32'(o_act_vld),   32'(0));
        check_eq({tag, "_done"},  32'(o_done),      32'(0));
        check_eq({tag, "_busy"},  32'(o_busy),      32'(0));
        check_eq({tag, "_count"}, 32'(o_count),     32'(0));
    endtask

    initial begin
        logic [ROWS*MUL_BW-1:0] d;
        logic                   v, l, a;

        rst     = 1'b0;
        i_vld   = 1'b0;
        i_data  = '0;
        i_last  = 1'b0;
        i_abort = 1'b0;
        clear_model();
        #1;
        check_zero_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst    = 1'b1;
        mon_en = 1'b1;
        idle(2);

        $display("[TB] single vector");
        apply_stimulus(1'b1, {16'h4000, 16'h3F80, 16'h4040, 16'h4080}, 1'b1, 1'b0);
        idle(ROWS + 2);

        $display("[TB] back-to-back stream");
        for (int k = 1; k <= 5; k++) apply_stimulus(1'b1, {ROWS{16'(k)}}, k == 5, 1'b0);
        idle(ROWS + 2);

        $display("[TB] bubble insertion");
        apply_stimulus(1'b1, {ROWS{16'h0001}}, 1'b0, 1'b0);
        idle(2);
        apply_stimulus(1'b1, {ROWS{16'h0002}}, 1'b1, 1'b0);
        idle(ROWS + 2);

        $display("[TB] abort mid-stream");
        for (int k = 1; k <= 3; k++) apply_stimulus(1'b1, {ROWS{16'(k + 16'h10)}}, 1'b0, 1'b0);
        apply_stimulus(1'b1, {ROWS{16'h0099}}, 1'b1, 1'b1);
        idle(ROWS + 2);

        $display("[TB] last without valid");
        apply_stimulus(1'b0, {ROWS{16'h0055}}, 1'b1, 1'b0);
        idle(2);

        $display("[TB] NaN and infinity elements");
        apply_stimulus(1'b1, {16'h7F80, 16'hFFC0, 16'h7F80, 16'h7FC1}, 1'b1, 1'b0);
        idle(ROWS + 2);

        $display("[TB] async reset during flush");
        apply_stimulus(1'b1, {ROWS{16'h0007}}, 1'b0, 1'b0);
        apply_stimulus(1'b1, {ROWS{16'h0008}}, 1'b1, 1'b0);
        idle(1);
        rst = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        clear_model();
        idle(2);
        rst = 1'b1;
        idle(ROWS + 3);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 7) == 0);
            a = ($urandom_range(0, 39) == 0);
            for (int r = 0; r < ROWS; r++) begin
                case ($urandom_range(0, 7))
                    0:       d[r*MUL_BW +: MUL_BW] = 16'h7FC1;
                    1:       d[r*MUL_BW +: MUL_BW] = 16'h7F80;
                    default: d[r*MUL_BW +: MUL_BW] = 16'($urandom);
                endcase
            end
            apply_stimulus(v, d, l, a);
        end
        idle(ROWS + 3);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
